cache_mem_bridge: RTL and testbench

- Sits directly downstream of the direct-mapped cache and services its memory traffic toward the backing RAM.
- Write-through stores are posted into a small write buffer and drained to memory in order.
- Read misses wait for the write buffer to drain, then issue a single read to memory. The fill word is returned to the cache with a one-cycle response pulse.
- Cache side and memory side both use valid/ready request handshakes.

---
 rtl/cache_mem_bridge_if.sv | 42 ++++
 rtl/cache_mem_bridge.sv | 128 ++++++++++++
 tb/tb_cache_mem_bridge.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_bridge_if.sv
// rtl/cache_mem_bridge_if.sv - cache-side and memory-side request/response bundle for cache_mem_bridge
interface cache_mem_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int WBUF_DEPTH = 4
);
    localparam int CNT_W = $clog2(WBUF_DEPTH) + 1;

    logic                  c_req_valid;
    logic                  c_req_ready;
    logic                  c_req_we;
    logic [ADDR_WIDTH-1:0] c_req_addr;
    logic [DATA_WIDTH-1:0] c_req_wdata;
    logic                  c_rsp_valid;
    logic [DATA_WIDTH-1:0] c_rsp_data;
    logic                  m_req_valid;
    logic                  m_req_ready;
    logic                  m_req_we;
    logic [ADDR_WIDTH-1:0] m_req_addr;
    logic [DATA_WIDTH-1:0] m_req_wdata;
    logic                  m_rsp_valid;
    logic [DATA_WIDTH-1:0] m_rsp_data;
    logic [CNT_W-1:0]      wbuf_count;
    logic                  busy;

    // The bridge itself uses the slave view; the cache/memory environment uses master.
    modport slave (
        input  c_req_valid, c_req_we, c_req_addr, c_req_wdata,
        input  m_req_ready, m_rsp_valid, m_rsp_data,
        output c_req_ready, c_rsp_valid, c_rsp_data,
        output m_req_valid, m_req_we, m_req_addr, m_req_wdata,
        output wbuf_count, busy
    );

    modport master (
        output c_req_valid, c_req_we, c_req_addr, c_req_wdata,
        output m_req_ready, m_rsp_valid, m_rsp_data,
        input  c_req_ready, c_rsp_valid, c_rsp_data,
        input  m_req_valid, m_req_we, m_req_addr, m_req_wdata,
        input  wbuf_count, busy
    );
endinterface

// File: rtl/cache_mem_bridge.sv
// rtl/cache_mem_bridge.sv - posted write buffer plus single-outstanding read path between cache and RAM
module cache_mem_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int WBUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    cache_mem_bridge_if.slave bus
);
    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~(ADDR_WIDTH'(DATA_WIDTH / 8) - ADDR_WIDTH'(1));
    localparam logic [CNT_W-1:0] FULL = CNT_W'(WBUF_DEPTH);

    typedef enum logic [1:0] {IDLE, DRAIN, RD_REQ, RD_WAIT} state_t;

    state_t                state_q, state_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_valid_q, rsp_valid_d;

    logic [ADDR_WIDTH-1:0] wbuf_addr_mem [WBUF_DEPTH];
    logic [DATA_WIDTH-1:0] wbuf_data_mem [WBUF_DEPTH];

    logic req_ready;
    logic accept;
    logic push;
    logic pop;
    logic drain_active;

    assign req_ready    = (state_q == IDLE) && (count_q < FULL);
    assign accept       = bus.c_req_valid && req_ready;
    assign push         = accept && bus.c_req_we;
    assign drain_active = ((state_q == IDLE) || (state_q == DRAIN)) && (count_q != '0);
    assign pop          = drain_active && bus.m_req_ready;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d     = count_q;
        rd_addr_d   = rd_addr_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;

        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (accept && !bus.c_req_we) begin
                    rd_addr_d = bus.c_req_addr & ALIGN_MASK;
                    state_d   = ((count_q == '0) && !push) ? RD_REQ : DRAIN;
                end
            end
            DRAIN: begin
                if ((count_q == '0) || (pop && (count_q == CNT_W'(1)))) begin
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                if (bus.m_req_ready) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (bus.m_rsp_valid) begin
                    rsp_data_d  = bus.m_rsp_data;
                    rsp_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_addr_q   <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_addr_q   <= rd_addr_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Entries are only read while count_q says they hold data, so storage needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            wbuf_addr_mem[wr_ptr_q] <= bus.c_req_addr & ALIGN_MASK;
            wbuf_data_mem[wr_ptr_q] <= bus.c_req_wdata;
        end
    end

    assign bus.c_req_ready = req_ready;
    assign bus.c_rsp_valid = rsp_valid_q;
    assign bus.c_rsp_data  = rsp_data_q;
    assign bus.m_req_valid = drain_active || (state_q == RD_REQ);
    assign bus.m_req_we    = drain_active;
    assign bus.m_req_addr  = drain_active ? wbuf_addr_mem[rd_ptr_q] :
                             (state_q == RD_REQ) ? rd_addr_q : '0;
    assign bus.m_req_wdata = drain_active ? wbuf_data_mem[rd_ptr_q] : '0;
    assign bus.wbuf_count  = count_q;
    assign bus.busy        = (state_q != IDLE) || (count_q != '0);

    wbuf_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && (count_q == FULL)));
    wbuf_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(pop && (count_q == '0)));
endmodule

// File: tb/tb_cache_mem_bridge.sv
// tb/tb_cache_mem_bridge.sv - self-checking bench for cache_mem_bridge
module tb_cache_mem_bridge;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam logic [AW-1:0] AMASK = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    cache_mem_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WBUF_DEPTH(DEPTH)) bus ();

    cache_mem_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WBUF_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [AW+DW-1:0] exp_w   [$];
    logic [AW-1:0]    exp_ra  [$];
    logic [DW-1:0]    exp_rsp [$];
    bit rand_rdy = 1'b0;
    bit last_acc = 1'b0;

    typedef struct {
        logic          v;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          mrdy;
        logic [2:0]    cnt;
        logic          rdy;
        logic          mv;
    } vec_t;
    vec_t vecs [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s actual=0x%0h required=none", name, act);
    endtask

    task automatic monitor();
        logic [AW+DW-1:0] w;
        if (reset_n && bus.m_req_valid && bus.m_req_ready) begin
            if (bus.m_req_we) begin
                if (exp_w.size() == 0) begin
                    flag("mem_write_unexpected", 64'(bus.m_req_addr));
                end else begin
                    w = exp_w.pop_front();
                    check("mem_wr_addr", 64'(bus.m_req_addr), 64'(w[AW+DW-1:DW]));
                    check("mem_wr_data", 64'(bus.m_req_wdata), 64'(w[DW-1:0]));
                end
            end else begin
                check("rd_after_drain", 64'(exp_w.size()), 64'd0);
                if (exp_ra.size() == 0) flag("mem_read_unexpected", 64'(bus.m_req_addr));
                else check("mem_rd_addr", 64'(bus.m_req_addr), 64'(exp_ra.pop_front()));
            end
        end
        if (bus.c_rsp_valid) begin
            if (exp_rsp.size() == 0) flag("c_rsp_unexpected", 64'(bus.c_rsp_data));
            else check("c_rsp_data", 64'(bus.c_rsp_data), 64'(exp_rsp.pop_front()));
        end
    endtask

    // One clock: observe at the falling edge, then move past the rising edge.
    task automatic step();
        @(negedge clk);
        last_acc = reset_n && bus.c_req_valid && bus.c_req_ready;
        monitor();
        @(posedge clk);
        #1;
        if (rand_rdy) bus.m_req_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        int n;
        n = 0;
        bus.c_req_valid = 1'b1;
        bus.c_req_we    = we;
        bus.c_req_addr  = addr;
        bus.c_req_wdata = data;
        if (we) exp_w.push_back({addr & AMASK, data});
        else    exp_ra.push_back(addr & AMASK);
        do begin
            step();
            n++;
        end while (!last_acc && n < 200);
        bus.c_req_valid = 1'b0;
        if (!last_acc) flag("send_timeout", 64'(addr));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0]  = '{1'b1, 1'b1, 32'h10, 32'd1, 1'b0, 3'd1, 1'b1, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 32'h14, 32'd2, 1'b0, 3'd2, 1'b1, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 32'h18, 32'd3, 1'b0, 3'd3, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 32'h1C, 32'd4, 1'b0, 3'd4, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,  32'd0, 1'b1, 3'd3, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 32'h24, 32'd5, 1'b1, 3'd3, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,  32'd0, 1'b1, 3'd2, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,  32'd0, 1'b1, 3'd1, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,  32'd0, 1'b1, 3'd0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 32'h2B, 32'd6, 1'b0, 3'd1, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 32'h0,  32'd0, 1'b1, 3'd0, 1'b1, 1'b0};

        reset_n         = 1'b0;
        bus.c_req_valid = 1'b0;
        bus.c_req_we    = 1'b0;
        bus.c_req_addr  = '0;
        bus.c_req_wdata = '0;
        bus.m_req_ready = 1'b0;
        bus.m_rsp_valid = 1'b0;
        bus.m_rsp_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_req_valid", 64'(bus.m_req_valid), 64'd0);
        check("rst_c_rsp_valid", 64'(bus.c_rsp_valid), 64'd0);
        reset_n = 1'b1;
        #1;
        check("idle_c_req_ready", 64'(bus.c_req_ready), 64'd1);
        check("idle_m_req_we", 64'(bus.m_req_we), 64'd0);
        check("idle_m_req_addr", 64'(bus.m_req_addr), 64'd0);
        check("idle_m_req_wdata", 64'(bus.m_req_wdata), 64'd0);
        check("idle_c_rsp_data", 64'(bus.c_rsp_data), 64'd0);
        check("idle_wbuf_count", 64'(bus.wbuf_count), 64'd0);
        check("idle_busy", 64'(bus.busy), 64'd0);

        // Fill to full with memory stalled, drain, push/pop in one cycle, unaligned write.
        for (int i = 0; i < 11; i++) begin
            bus.c_req_valid = vecs[i].v;
            bus.c_req_we    = vecs[i].we;
            bus.c_req_addr  = vecs[i].addr;
            bus.c_req_wdata = vecs[i].data;
            bus.m_req_ready = vecs[i].mrdy;
            if (vecs[i].v && vecs[i].we) exp_w.push_back({vecs[i].addr & AMASK, vecs[i].data});
            step();
            check($sformatf("vec%0d_count", i), 64'(bus.wbuf_count), 64'(vecs[i].cnt));
            check($sformatf("vec%0d_ready", i), 64'(bus.c_req_ready), 64'(vecs[i].rdy));
            check($sformatf("vec%0d_mvalid", i), 64'(bus.m_req_valid), 64'(vecs[i].mv));
        end
        bus.c_req_valid = 1'b0;
        bus.m_req_ready = 1'b0;

        // Read with the buffer empty, stalled five cycles in the request phase.
        send(1'b0, 32'h0000_1237, '0);
        check("rd_t1_valid", 64'(bus.m_req_valid), 64'd1);
        check("rd_t1_we", 64'(bus.m_req_we), 64'd0);
        check("rd_t1_addr", 64'(bus.m_req_addr), 64'h1234);
        check("rd_t1_ready", 64'(bus.c_req_ready), 64'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", 64'(bus.m_req_valid), 64'd1);
            check("stall_we", 64'(bus.m_req_we), 64'd0);
            check("stall_addr", 64'(bus.m_req_addr), 64'h1234);
        end
        bus.m_req_ready = 1'b1;
        step();
        bus.m_req_ready = 1'b0;
        check("rd_wait_mvalid", 64'(bus.m_req_valid), 64'd0);
        step();
        step();
        check("rd_wait_ready", 64'(bus.c_req_ready), 64'd0);
        bus.m_rsp_valid = 1'b1;
        bus.m_rsp_data  = 32'hDEAD_BEEF;
        exp_rsp.push_back(32'hDEAD_BEEF);
        step();
        bus.m_rsp_valid = 1'b0;
        check("rsp_pulse", 64'(bus.c_rsp_valid), 64'd1);
        check("rsp_data", 64'(bus.c_rsp_data), 64'hDEAD_BEEF);
        step();
        check("rsp_pulse_end", 64'(bus.c_rsp_valid), 64'd0);
        check("rsp_data_hold", 64'(bus.c_rsp_data), 64'hDEAD_BEEF);

        // Memory response while idle must be ignored.
        bus.m_rsp_valid = 1'b1;
        bus.m_rsp_data  = 32'h1234_5678;
        step();
        bus.m_rsp_valid = 1'b0;
        check("spur_rsp_valid", 64'(bus.c_rsp_valid), 64'd0);
        check("spur_rsp_data", 64'(bus.c_rsp_data), 64'hDEAD_BEEF);
        step();
        check("spur_rsp_valid2", 64'(bus.c_rsp_valid), 64'd0);
        check("spur_busy", 64'(bus.busy), 64'd0);

        // Two posted writes then a read: read reaches memory only after both writes.
        send(1'b1, 32'h30, 32'hA);
        send(1'b1, 32'h34, 32'hB);
        send(1'b0, 32'h20, '0);
        check("drn_ready", 64'(bus.c_req_ready), 64'd0);
        check("drn_count", 64'(bus.wbuf_count), 64'd2);
        bus.m_req_ready = 1'b1;
        n = 0;
        while (exp_ra.size() != 0 && n < 20) begin
            step();
            check("drn_ready_low", 64'(bus.c_req_ready), 64'd0);
            n++;
        end
        if (exp_ra.size() != 0) flag("drn_read_timeout", 64'(n));
        bus.m_req_ready = 1'b0;
        step();
        check("drn_wait_ready", 64'(bus.c_req_ready), 64'd0);
        bus.m_rsp_valid = 1'b1;
        bus.m_rsp_data  = 32'hCAFE_F00D;
        exp_rsp.push_back(32'hCAFE_F00D);
        step();
        bus.m_rsp_valid = 1'b0;
        check("drn_rsp_pulse", 64'(bus.c_rsp_valid), 64'd1);
        step();

        // Asynchronous reset in the middle of a drain.
        send(1'b1, 32'h40, 32'h11);
        send(1'b1, 32'h44, 32'h22);
        send(1'b0, 32'h48, '0);
        check("mid_drain_mvalid", 64'(bus.m_req_valid), 64'd1);
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_async_mvalid", 64'(bus.m_req_valid), 64'd0);
        check("rst_async_count", 64'(bus.wbuf_count), 64'd0);
        check("rst_async_busy", 64'(bus.busy), 64'd0);
        exp_w.delete();
        exp_ra.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        bus.m_req_ready = 1'b1;
        repeat (3) step();
        check("rst_after_ready", 64'(bus.c_req_ready), 64'd1);
        check("rst_after_rsp", 64'(bus.c_rsp_valid), 64'd0);

        // Ten writes through the four-entry buffer with random memory backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(1'b1, AW'(32'h100 + 4 * i), DW'(32'h1000 + i));
        end
        rand_rdy = 1'b0;
        bus.m_req_ready = 1'b1;
        n = 0;
        while (bus.wbuf_count != '0 && n < 50) begin
            step();
            n++;
        end
        step();
        check("wrap_drained", 64'(exp_w.size()), 64'd0);
        check("wrap_count", 64'(bus.wbuf_count), 64'd0);
        check("end_rd_queue", 64'(exp_ra.size()), 64'd0);
        check("end_rsp_queue", 64'(exp_rsp.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
